// File: rtl/width_conv_socket.sv
// Buffering socket with elaboration-time width conversion: packs narrow producer
// slices into wide words, unpacks wide words into narrow slices, or acts as a plain FIFO.
module width_conv_socket #(
    parameter int IN_W      = 1,
    parameter int OUT_W     = 4,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clr,
    input  logic                         i_wr,
    input  logic [IN_W-1:0]              i_data,
    output logic                         o_full,
    input  logic                         i_rd,
    output logic [OUT_W-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_err
);
    localparam int W  = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int N  = (IN_W > OUT_W) ? OUT_W : IN_W;
    localparam int R  = W / N;
    // Pack ratio and unpack ratio; the unused one is 1 so equal mode falls out of both paths.
    localparam int PR = (OUT_W > IN_W) ? R : 1;
    localparam int UR = (IN_W > OUT_W) ? R : 1;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PLAST  = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LFULL  = LW'(DEPTH);
    localparam logic [CW-1:0] PCLAST = CW'(PR - 1);
    localparam logic [CW-1:0] UCLAST = CW'(UR - 1);

    generate
        if (W % N != 0) begin : g_bad_ratio
            $error("width_conv_socket: IN_W and OUT_W must divide one another");
        end
    endgenerate

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [W-1:0]  acc, din_sh, word, head;
    logic [CW-1:0] acnt, acnt_n, sidx;
    logic [LW-1:0] lvl_n;
    logic          wr_ok, rd_ok, push, pop;
    int            pslot, uslot;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ok  = i_wr && !o_full;
        rd_ok  = i_rd && !o_empty;
        push   = wr_ok && (acnt == PCLAST);
        pop    = rd_ok && (sidx == UCLAST);
        pslot  = (MSB_FIRST != 0) ? (PR - 1 - int'(acnt)) : int'(acnt);
        uslot  = (MSB_FIRST != 0) ? (UR - 1 - int'(sidx)) : int'(sidx);
        din_sh = W'(i_data) << (pslot * IN_W);
        word   = acc | din_sh;
        head   = mem[rptr];
        o_data = o_empty ? '0 : OUT_W'(head >> (uslot * OUT_W));
        lvl_n  = o_level + LW'(push) - LW'(pop);
        acnt_n = wr_ok ? (push ? '0 : acnt + 1'b1) : acnt;
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_clr) mem[wptr] <= word;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr <= '0; rptr <= '0; acc <= '0; acnt <= '0; sidx <= '0;
            o_level <= '0; o_full <= 1'b0; o_empty <= 1'b1; o_err <= 1'b0;
        end else if (i_clr) begin
            wptr <= '0; rptr <= '0; acc <= '0; acnt <= '0; sidx <= '0;
            o_level <= '0; o_full <= 1'b0; o_empty <= 1'b1; o_err <= 1'b0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop)  rptr <= nxt(rptr);
            if (wr_ok) acc <= push ? '0 : word;
            if (rd_ok) sidx <= pop ? '0 : sidx + 1'b1;
            acnt    <= acnt_n;
            o_level <= lvl_n;
            // Full only blocks the write that would complete a word into a full FIFO.
            o_full  <= (lvl_n == LFULL) && (acnt_n == PCLAST);
            o_empty <= (lvl_n == '0);
            if ((i_wr && o_full) || (i_rd && o_empty)) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_width_conv_socket.sv
// Bench for width_conv_socket: two pack instances (MSB/LSB first) sharing stimulus,
// one 7->1 unpack instance; reference queues hold expected output words.
module tb_width_conv_socket;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    always #5 clk = ~clk;

    logic       p_wr = 1'b0, p_din = 1'b0, p_rd = 1'b0;
    logic       a_full, a_empty, a_err, b_full, b_empty, b_err;
    logic [3:0] a_data, b_data;
    logic [2:0] a_level, b_level;

    logic       u_wr = 1'b0, u_rd = 1'b0;
    logic [6:0] u_din = '0;
    logic       u_full, u_empty, u_err;
    logic [0:0] u_data;
    logic [1:0] u_level;

    width_conv_socket #(.IN_W(1), .OUT_W(4), .DEPTH(4), .MSB_FIRST(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(p_wr), .i_data(p_din), .o_full(a_full),
        .i_rd(p_rd), .o_data(a_data), .o_empty(a_empty), .o_level(a_level), .o_err(a_err));
    width_conv_socket #(.IN_W(1), .OUT_W(4), .DEPTH(4), .MSB_FIRST(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(p_wr), .i_data(p_din), .o_full(b_full),
        .i_rd(p_rd), .o_data(b_data), .o_empty(b_empty), .o_level(b_level), .o_err(b_err));
    width_conv_socket #(.IN_W(7), .OUT_W(1), .DEPTH(3), .MSB_FIRST(1)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(u_wr), .i_data(u_din), .o_full(u_full),
        .i_rd(u_rd), .o_data(u_data), .o_empty(u_empty), .o_level(u_level), .o_err(u_err));

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference state
    int         p_lvl, p_cnt, u_lvl, u_idx;
    bit         p_err, u_err_m;
    logic [3:0] p_wm, p_wl;
    logic [3:0] qa[$], qb[$];
    logic [6:0] uq[$];

    task automatic mreset();
        p_lvl = 0; p_cnt = 0; p_err = 0; p_wm = '0; p_wl = '0;
        u_lvl = 0; u_idx = 0; u_err_m = 0;
        qa.delete(); qb.delete(); uq.delete();
    endtask

    task automatic step_p(input logic wr, input logic d, input logic rd);
        logic pfull;
        logic [3:0] ea, eb;
        @(negedge clk);
        pfull = (p_lvl == 4) && (p_cnt == 3);
        ea = (p_lvl == 0) ? 4'd0 : qa[0];
        eb = (p_lvl == 0) ? 4'd0 : qb[0];
        chk("a_level", a_level, p_lvl);
        chk("a_full", a_full, pfull);
        chk("a_empty", a_empty, p_lvl == 0);
        chk("a_err", a_err, p_err);
        chk("a_data", a_data, ea);
        chk("b_data", b_data, eb);
        chk("b_full", b_full, pfull);
        if ((wr && pfull) || (rd && p_lvl == 0)) p_err = 1;
        if (rd && p_lvl != 0) begin
            void'(qa.pop_front()); void'(qb.pop_front()); p_lvl--;
        end
        if (wr && !pfull) begin
            p_wm = {p_wm[2:0], d};
            p_wl[p_cnt] = d;
            p_cnt++;
            if (p_cnt == 4) begin
                qa.push_back(p_wm); qb.push_back(p_wl);
                p_lvl++; p_cnt = 0; p_wm = '0; p_wl = '0;
            end
        end
        p_wr = wr; p_din = d; p_rd = rd;
    endtask

    task automatic step_u(input logic wr, input logic [6:0] d, input logic rd);
        logic       ufull, eu;
        logic [6:0] h;
        @(negedge clk);
        ufull = (u_lvl == 3);
        h = (u_lvl == 0) ? 7'd0 : uq[0];
        eu = (u_lvl == 0) ? 1'b0 : h[6 - u_idx];
        chk("u_level", u_level, u_lvl);
        chk("u_full", u_full, ufull);
        chk("u_empty", u_empty, u_lvl == 0);
        chk("u_err", u_err, u_err_m);
        chk("u_data", u_data, eu);
        if ((wr && ufull) || (rd && u_lvl == 0)) u_err_m = 1;
        if (rd && u_lvl != 0) begin
            if (u_idx == 6) begin void'(uq.pop_front()); u_lvl--; u_idx = 0; end
            else u_idx++;
        end
        if (wr && !ufull) begin uq.push_back(d); u_lvl++; end
        u_wr = wr; u_din = d; u_rd = rd;
    endtask

    task automatic do_clr(input logic w, input logic [6:0] d);
        @(negedge clk);
        p_wr = 1'b1; p_rd = 1'b1; u_wr = w; u_din = d; u_rd = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; p_wr = 1'b0; p_rd = 1'b0; u_wr = 1'b0; u_rd = 1'b0;
        mreset();
    endtask

    initial begin
        int sent;
        logic wr;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_a_empty", a_empty, 1'b1);
        chk("rst_a_data", a_data, 4'd0);
        chk("rst_u_level", u_level, 2'd0);
        rst = 1'b0;

        // Pack ordering
        step_p(1, 1, 0); step_p(1, 0, 0); step_p(1, 1, 0); step_p(1, 1, 0);
        step_p(0, 0, 0);
        chk("t1_msb", a_data, 4'b1011);
        chk("t2_lsb", b_data, 4'b1101);
        chk("t1_level", a_level, 3'd1);
        step_p(0, 0, 1); step_p(0, 0, 0);

        // Pack fill, drop on full, relieve with one read
        do_clr(0, '0);
        for (int i = 0; i < 20; i++) step_p(1, 1'($urandom % 2), 0);
        step_p(0, 0, 1);
        step_p(1, 1'($urandom % 2), 0);
        step_p(0, 0, 0);
        repeat (5) step_p(0, 0, 1);
        step_p(0, 0, 0);

        // Async reset mid-operation with level 2 and 3 partial slices
        do_clr(0, '0);
        step_p(0, 0, 1);
        for (int i = 0; i < 11; i++) step_p(1, 1'($urandom % 2), 0);
        step_p(0, 0, 0);
        @(negedge clk); #2 rst = 1'b1; #1;
        chk("ar_full", a_full, 1'b0);
        chk("ar_empty", a_empty, 1'b1);
        chk("ar_level", a_level, 3'd0);
        chk("ar_data", a_data, 4'd0);
        chk("ar_err", a_err, 1'b0);
        @(negedge clk); rst = 1'b0; mreset();
        step_p(1, 0, 0); step_p(1, 1, 0); step_p(1, 1, 0);
        step_p(0, 0, 0);
        chk("ar_partial", a_level, 3'd0);
        step_p(1, 0, 0); step_p(0, 0, 0);
        chk("ar_word", a_data, 4'b0110);
        step_p(0, 0, 1); step_p(0, 0, 0);

        // Unpack single word then streaming across pointer wrap
        do_clr(0, '0);
        step_u(1, 7'b1100101, 0);
        repeat (7) step_u(0, '0, 1);
        step_u(0, '0, 0);
        chk("t4_empty", u_empty, 1'b1);
        sent = 0;
        for (int c = 0; c < 120; c++) begin
            wr = (sent < 10);
            if (wr && u_lvl != 3) begin
                step_u(1, 7'(sent * 37 + 5), 1);
                sent++;
            end else step_u(wr, 7'(sent * 37 + 5), 1);
        end
        step_u(0, '0, 0);

        // Underflow error, then clear beating a simultaneous write
        do_clr(0, '0);
        step_u(0, '0, 1);
        step_u(0, '0, 0);
        chk("t5_err", u_err, 1'b1);
        do_clr(1, 7'h55);
        step_u(0, '0, 0);
        chk("t5_clr_err", u_err, 1'b0);
        chk("t5_clr_lvl", u_level, 2'd0);
        step_u(0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
